mips_cpu_dmemory_avalon: RTL and testbench

Parametrised word-organised data memory for the MIPS CPU data port, replacing the fixed 32-bit, zero-latency, always-ready data memory. Presents an Avalon-style slave interface with waitrequest, per-byte write enables, and a configurable stall length. Flags misaligned and out-of-range accesses. Sits between the CPU load/store unit and backing storage; behaviour is deterministic so the CPU stall logic can be exercised in simulation.

---
 rtl/mips_cpu_dmemory_avalon.sv | 98 +++++++++
 tb/tb_mips_cpu_dmemory_avalon.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_dmemory_avalon.sv
// rtl/mips_cpu_dmemory_avalon.sv - Avalon-style data memory with waitrequest stalls and access checks
// Word-organised storage; each request is latched, stalled WAIT_CYCLES, committed, then held for one DONE cycle.
module mips_cpu_dmemory_avalon #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int WAIT_CYCLES   = 0,
  parameter     MEM_INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [7:0]              counter;
  logic [31:0]             addr_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [NB-1:0]           be_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    reject;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   word_idx;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign word_idx    = addr_q[ADDR_WIDTH+1:2];
  assign reject      = (addr_q[1:0] != 2'b00) || (|addr_q[31:ADDR_WIDTH+2]) || (rd_q && wr_q);
  assign commit      = (state == BUSY) && (counter == 8'd0);
  assign waitrequest = (read || write) && (state != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      counter  <= 8'd0;
      readdata <= '0;
      err      <= 1'b0;
      addr_q   <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      wd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read || write) begin
            addr_q  <= address;
            rd_q    <= read;
            wr_q    <= write;
            be_q    <= byteenable;
            wd_q    <= writedata;
            counter <= WAIT_LD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (counter != 8'd0) begin
            counter <= counter - 8'd1;
          end else begin
            err <= reject;
            if (reject)    readdata <= '0;
            else if (rd_q) readdata <= mem[word_idx];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes land on the same edge that moves BUSY to DONE, so a following read sees them.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !reject) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[word_idx][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_dmemory_avalon.sv
// tb/tb_mips_cpu_dmemory_avalon.sv - self-checking bench for mips_cpu_dmemory_avalon
// Three instances with stall lengths 0, 3 and 4 are checked against a word-array reference model.
module tb_mips_cpu_dmemory_avalon;

  logic        clk = 1'b0;
  logic        reset_n     [3];
  logic [31:0] address     [3];
  logic        read        [3];
  logic        write       [3];
  logic [3:0]  byteenable  [3];
  logic [31:0] writedata   [3];
  logic        waitrequest [3];
  logic [31:0] readdata    [3];
  logic        err         [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl     [3][1024];
  logic [31:0] rd_hold [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_cpu_dmemory_avalon #(
      .ADDR_WIDTH(10),
      .DATA_WIDTH(32),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 4)),
      .MEM_INIT_FILE("")
    ) u_dut (
      .clk(clk),
      .reset_n(reset_n[g]),
      .address(address[g]),
      .read(read[g]),
      .write(write[g]),
      .byteenable(byteenable[g]),
      .writedata(writedata[g]),
      .waitrequest(waitrequest[g]),
      .readdata(readdata[g]),
      .err(err[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
  endfunction

  // Reference: what a completed access must report and leave behind in storage.
  function automatic void model_access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                                       input logic [3:0] b, input logic [31:0] w,
                                       output logic [31:0] exp_rd, output logic exp_err);
    bit rej;
    int idx;
    rej = (a % 4 != 0) || (a >= 32'd4096) || (rd && wr);
    idx = int'(a / 4) % 1024;
    if (rej) begin
      exp_err    = 1'b1;
      rd_hold[d] = 32'd0;
    end else begin
      exp_err = 1'b0;
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) mdl[d][idx][8*i +: 8] = w[8*i +: 8];
      end else begin
        rd_hold[d] = mdl[d][idx];
      end
    end
    exp_rd = rd_hold[d];
  endfunction

  // Called at a negedge; leaves the request asserted through the DONE cycle.
  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] w, input bit b2b, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    model_access(d, rd, wr, a, b, w, exp_rd, exp_err);
    address[d] = a; read[d] = rd; write[d] = wr; byteenable[d] = b; writedata[d] = w;
    #1;
    if (!b2b) begin
      checks++;
      if (waitrequest[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s wait_c0: got %b expected 1", tag, waitrequest[d]);
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitrequest[d] !== 1'b0 && n < 300);
    checks++;
    if (n != wait_of(d) + 2 + int'(b2b)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected %0d", tag, n, wait_of(d) + 2 + int'(b2b));
    end
    checks++;
    if (err[d] !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", tag, err[d], exp_err);
    end
    checks++;
    if (readdata[d] !== exp_rd) begin
      errors++;
      $display("FAIL %s readdata: got %h expected %h", tag, readdata[d], exp_rd);
    end
  endtask

  task automatic idle(input int d);
    read[d] = 1'b0; write[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (waitrequest[d] !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: got %b expected 0", waitrequest[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      reset_n[d] = 1'b0; read[d] = 1'b0; write[d] = 1'b0;
      address[d] = 32'd0; byteenable[d] = 4'd0; writedata[d] = 32'd0; rd_hold[d] = 32'd0;
      for (int i = 0; i < 1024; i++) mdl[d][i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (waitrequest[d] !== 1'b0 || readdata[d] !== 32'd0 || err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values: got wr=%b rd=%h err=%b expected 0/0/0", waitrequest[d], readdata[d], err[d]);
      end
      reset_n[d] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    access(0, 0, 1, 32'h10, 4'hF, 32'h11223344, 0, "basic_wr"); idle(0);
    access(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, "basic_rd");
    checks++;
    if (readdata[0] !== 32'h11223344) begin
      errors++;
      $display("FAIL basic_const: got %h expected 11223344", readdata[0]);
    end
    idle(0);
  endtask

  task automatic test_byte_lanes();
    access(0, 0, 1, 32'h20, 4'hF, 32'hAABBCCDD, 0, "lane_pre"); idle(0);
    access(0, 0, 1, 32'h20, 4'b0001, 32'h00000055, 0, "lane_b0"); idle(0);
    access(0, 0, 1, 32'h20, 4'b1000, 32'h66000000, 0, "lane_b3"); idle(0);
    access(0, 0, 1, 32'h20, 4'b0000, 32'hFFFFFFFF, 0, "lane_none"); idle(0);
    access(0, 1, 0, 32'h20, 4'hF, 32'h0, 0, "lane_rd");
    checks++;
    if (readdata[0] !== 32'h66BBCC55) begin
      errors++;
      $display("FAIL lane_const: got %h expected 66bbcc55", readdata[0]);
    end
    idle(0);
  endtask

  task automatic test_wait_states();
    access(1, 0, 1, 32'h20, 4'hF, 32'hAABBCCDD, 0, "wait_wr"); idle(1);
    access(1, 1, 0, 32'h20, 4'hF, 32'h0, 0, "wait_rd");
    // Request left asserted across DONE must be seen as a fresh one.
    access(1, 1, 0, 32'h20, 4'hF, 32'h0, 1, "wait_again");
    idle(1);
  endtask

  task automatic test_reject();
    access(0, 1, 0, 32'h22, 4'hF, 32'h0, 0, "rej_misalign"); idle(0);
    access(0, 1, 0, 32'h1000, 4'hF, 32'h0, 0, "rej_range"); idle(0);
    access(0, 0, 1, 32'h12, 4'hF, 32'hCAFEF00D, 0, "rej_wr_mis"); idle(0);
    access(0, 1, 0, 32'h10, 4'hF, 32'h0, 0, "rej_check_mem"); idle(0);
    access(0, 1, 0, 32'h0, 4'hF, 32'h0, 0, "rej_after"); idle(0);
  endtask

  task automatic test_reset_in_busy();
    access(2, 0, 1, 32'h30, 4'hF, 32'h12345678, 0, "rst_pre"); idle(2);
    address[2] = 32'h30; write[2] = 1'b1; byteenable[2] = 4'hF; writedata[2] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    reset_n[2] = 1'b0;
    #1;
    checks++;
    if (waitrequest[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_req: got %b expected 1", waitrequest[2]);
    end
    write[2] = 1'b0;
    #1;
    checks++;
    if (waitrequest[2] !== 1'b0 || readdata[2] !== 32'd0 || err[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got wr=%b rd=%h err=%b expected 0/0/0", waitrequest[2], readdata[2], err[2]);
    end
    rd_hold[2] = 32'd0;
    @(negedge clk);
    reset_n[2] = 1'b1;
    @(negedge clk);
    access(2, 1, 0, 32'h30, 4'hF, 32'h0, 0, "rst_old_val"); idle(2);
  endtask

  task automatic test_rw_conflict();
    access(0, 1, 1, 32'h40, 4'hF, 32'h5A5A5A5A, 0, "conflict"); idle(0);
    access(0, 1, 0, 32'h40, 4'hF, 32'h0, 0, "conflict_mem"); idle(0);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        bit          rd;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] w;
        rd = bit'($urandom_range(0, 1));
        a  = 32'h100 + 32'($urandom_range(0, 3)) * 4;
        b  = 4'($urandom);
        w  = $urandom;
        access(d, rd, !rd, a, b, w, k != 0, "b2b");
      end
      idle(d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_reject();
    test_reset_in_busy();
    test_rw_conflict();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
